// File: rtl/core_pkg.sv
// Shared definitions for the write-back path: requester indices and the
// per-requester result record.
package core_pkg;

  localparam int NREQ    = 3;
  localparam int REQ_ALU = 0;
  localparam int REQ_FPU = 1;
  localparam int REQ_LSU = 2;
  localparam int DATA_W  = 32;

  typedef struct packed {
    logic [4:0]        addr;
    logic              is_float;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/core_rr_arb.sv
// N-way round-robin arbiter: combinational one-hot grant, pointer advances
// past the winner on every grant and holds otherwise.
module core_rr_arb
  import core_pkg::*;
#(
  parameter int N = NREQ
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] valid,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW:0]   pos;
  logic          found;

  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
      if (!found && valid[pos[PW-1:0]]) begin
        found              = 1'b1;
        grant[pos[PW-1:0]] = 1'b1;
        ptr_nxt            = (pos[PW-1:0] == PW'(N-1)) ? '0 : pos[PW-1:0] + PW'(1);
      end
    end
    // No handshakes may complete while reset is held.
    if (RST) grant = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) ptr <= '0;
    else     ptr <= ptr_nxt;
  end

endmodule

// File: rtl/core_wb_arbiter.sv
// Write-back arbiter and register scoreboard: shares the register-file write
// port among ALU/FPU/LSU and reports RAW/WAW hazards to decode.
module core_wb_arbiter
  import core_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NREQ-1:0]        REQ_VALID,
  output logic [NREQ-1:0]        REQ_READY,
  input  logic [5*NREQ-1:0]      REQ_ADDR,
  input  logic [NREQ-1:0]        REQ_FLOAT,
  input  logic [DATA_W*NREQ-1:0] REQ_DATA,
  input  logic                   ISSUE_VALID,
  input  logic [4:0]             ISSUE_ADDR,
  input  logic                   ISSUE_FLOAT,
  input  logic [4:0]             CHK_RS1ADDR,
  input  logic [4:0]             CHK_RS2ADDR,
  input  logic [4:0]             CHK_RDADDR,
  input  logic                   CHK_RS1FLOAT,
  input  logic                   CHK_RS2FLOAT,
  input  logic                   CHK_RDFLOAT,
  output logic                   HAZARD,
  output logic                   WE,
  output logic [4:0]             WADDR,
  output logic [4:0]             FWADDR,
  output logic [DATA_W-1:0]      WDATA
);

  wb_req_t           req [NREQ];
  wb_req_t           sel;
  logic [NREQ-1:0]   grant;
  logic              hs;
  logic              wr;
  logic [31:0]       busy_int;
  logic [31:0]       busy_fp;
  logic              vld_p1;
  logic [4:0]        waddr_p1;
  logic [4:0]        fwaddr_p1;
  logic [DATA_W-1:0] wdata_p1;

  function automatic logic is_busy(input logic [31:0] bi, input logic [31:0] bf,
                                   input logic [4:0] a, input logic f);
    return f ? bf[a] : bi[a];
  endfunction

  core_rr_arb #(.N(NREQ)) u_arb (
    .CLK   (CLK),
    .RST   (RST),
    .valid (REQ_VALID),
    .grant (grant)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req[i].addr     = REQ_ADDR[5*i +: 5];
      req[i].is_float = REQ_FLOAT[i];
      req[i].data     = REQ_DATA[DATA_W*i +: DATA_W];
    end
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) sel = req[i];
  end

  assign REQ_READY = grant;
  assign hs        = |grant;
  assign wr        = hs && (sel.addr != 5'd0);

  // Bit 0 of each map is never set, so x0/f0 always read as free.
  assign HAZARD = is_busy(busy_int, busy_fp, CHK_RS1ADDR, CHK_RS1FLOAT)
                | is_busy(busy_int, busy_fp, CHK_RS2ADDR, CHK_RS2FLOAT)
                | is_busy(busy_int, busy_fp, CHK_RDADDR,  CHK_RDFLOAT);

  // Scoreboard: the issue set is written last so it overrides a same-cycle retire.
  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_int <= '0;
      busy_fp  <= '0;
    end else begin
      if (wr) begin
        if (sel.is_float) busy_fp[sel.addr]  <= 1'b0;
        else              busy_int[sel.addr] <= 1'b0;
      end
      if (ISSUE_VALID && ISSUE_ADDR != 5'd0) begin
        if (ISSUE_FLOAT) busy_fp[ISSUE_ADDR]  <= 1'b1;
        else             busy_int[ISSUE_ADDR] <= 1'b1;
      end
    end
  end

  // Stage p1: registered register-file write port
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p1    <= 1'b0;
      waddr_p1  <= '0;
      fwaddr_p1 <= '0;
      wdata_p1  <= '0;
    end else begin
      vld_p1    <= wr;
      waddr_p1  <= (wr && !sel.is_float) ? sel.addr : 5'd0;
      fwaddr_p1 <= (wr &&  sel.is_float) ? sel.addr : 5'd0;
      wdata_p1  <= wr ? sel.data : '0;
    end
  end

  assign WE     = vld_p1;
  assign WADDR  = waddr_p1;
  assign FWADDR = fwaddr_p1;
  assign WDATA  = wdata_p1;

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Directed bench for core_wb_arbiter: stimulus pushes expected writes into a
// queue, a negedge monitor pops them whenever the write port fires.
module tb_core_wb_arbiter;
  import core_pkg::*;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [NREQ-1:0]   REQ_VALID = '0;
  logic [NREQ-1:0]   REQ_READY;
  logic [NREQ-1:0]   REQ_FLOAT = '0;
  logic [4:0]        r_addr [NREQ];
  logic [31:0]       r_data [NREQ];
  logic [5*NREQ-1:0] REQ_ADDR;
  logic [32*NREQ-1:0] REQ_DATA;
  logic              ISSUE_VALID = 1'b0;
  logic [4:0]        ISSUE_ADDR = '0;
  logic              ISSUE_FLOAT = 1'b0;
  logic [4:0]        CHK_RS1ADDR = '0, CHK_RS2ADDR = '0, CHK_RDADDR = '0;
  logic              CHK_RS1FLOAT = 1'b0, CHK_RS2FLOAT = 1'b0, CHK_RDFLOAT = 1'b0;
  logic              HAZARD, WE;
  logic [4:0]        WADDR, FWADDR;
  logic [31:0]       WDATA;

  assign REQ_ADDR = {r_addr[REQ_LSU], r_addr[REQ_FPU], r_addr[REQ_ALU]};
  assign REQ_DATA = {r_data[REQ_LSU], r_data[REQ_FPU], r_data[REQ_ALU]};

  core_wb_arbiter dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR),
    .REQ_FLOAT(REQ_FLOAT), .REQ_DATA(REQ_DATA),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_ADDR(ISSUE_ADDR), .ISSUE_FLOAT(ISSUE_FLOAT),
    .CHK_RS1ADDR(CHK_RS1ADDR), .CHK_RS2ADDR(CHK_RS2ADDR), .CHK_RDADDR(CHK_RDADDR),
    .CHK_RS1FLOAT(CHK_RS1FLOAT), .CHK_RS2FLOAT(CHK_RS2FLOAT), .CHK_RDFLOAT(CHK_RDFLOAT),
    .HAZARD(HAZARD), .WE(WE), .WADDR(WADDR), .FWADDR(FWADDR), .WDATA(WDATA)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  wa;
    logic [4:0]  fa;
    logic [31:0] d;
  } wr_t;

  wr_t        expq [$];
  int         checks = 0;
  int         passes = 0;
  bit         mon_en = 1'b0;
  logic [2:0] fair [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_wb(input int g);
    wr_t e;
    if (r_addr[g] != 5'd0) begin
      e.wa = REQ_FLOAT[g] ? 5'd0 : r_addr[g];
      e.fa = REQ_FLOAT[g] ? r_addr[g] : 5'd0;
      e.d  = r_data[g];
      expq.push_back(e);
    end
  endtask

  task automatic grant_cycle(input logic [2:0] exp_g, input string nm);
    #3;
    chk(nm, REQ_READY, exp_g);
    for (int g = 0; g < NREQ; g++)
      if (exp_g[g]) expect_wb(g);
  endtask

  always @(negedge CLK) begin
    wr_t e;
    if (mon_en) begin
      if (WE) begin
        if (expq.size() == 0) begin
          checks++;
          $display("FAIL wb_unexpected: WE=1 WADDR=%0d FWADDR=%0d WDATA=%h, expected no write",
                   WADDR, FWADDR, WDATA);
        end else begin
          e = expq.pop_front();
          chk("wb_waddr", 32'(WADDR), 32'(e.wa));
          chk("wb_fwaddr", 32'(FWADDR), 32'(e.fa));
          chk("wb_wdata", WDATA, e.d);
        end
      end else begin
        chk("wb_idle_addr", {22'd0, WADDR, FWADDR}, 32'd0);
        chk("wb_idle_data", WDATA, 32'd0);
      end
    end
  end

  initial begin
    r_addr[REQ_ALU] = 5'd1; r_data[REQ_ALU] = 32'hA0A0_0001;
    r_addr[REQ_FPU] = 5'd2; r_data[REQ_FPU] = 32'hB0B0_0002;
    r_addr[REQ_LSU] = 5'd3; r_data[REQ_LSU] = 32'hC0C0_0003;
    REQ_FLOAT = 3'b010;
    REQ_VALID = 3'b111;

    repeat (2) begin
      @(posedge CLK);
      #4;
      chk("rst_ready", REQ_READY, 32'd0);
    end

    // Release reset with all requesters valid: fairness rotation.
    step();
    RST    = 1'b0;
    mon_en = 1'b1;
    grant_cycle(fair[0], "fair_grant0");
    chk("rst_we", WE, 1'b0);
    chk("rst_hazard", HAZARD, 1'b0);
    for (int i = 1; i < 6; i++) begin
      step();
      grant_cycle(fair[i], $sformatf("fair_grant%0d", i));
    end

    // Scoreboard RAW on x5.
    step();
    REQ_VALID = '0;
    ISSUE_VALID = 1'b1; ISSUE_ADDR = 5'd5; ISSUE_FLOAT = 1'b0;
    CHK_RDADDR = 5'd5;
    #3 chk("issue_x5_rd_free", HAZARD, 1'b0);
    step();
    ISSUE_VALID = 1'b0; CHK_RDADDR = 5'd0; CHK_RS1ADDR = 5'd5;
    #3 chk("raw_x5_int", HAZARD, 1'b1);
    step();
    CHK_RS1FLOAT = 1'b1;
    #3 chk("raw_f5_float", HAZARD, 1'b0);
    step();
    CHK_RS1FLOAT = 1'b0;
    REQ_VALID = 3'b001; r_addr[REQ_ALU] = 5'd5; r_data[REQ_ALU] = 32'hDEAD_BEEF;
    grant_cycle(3'b001, "ret_x5_grant");
    chk("raw_x5_no_bypass", HAZARD, 1'b1);
    step();
    REQ_VALID = '0;
    #3 chk("raw_x5_cleared", HAZARD, 1'b0);

    // Float destination, then a discarded x0 result.
    step();
    CHK_RS1ADDR = 5'd0;
    REQ_VALID = 3'b010; r_addr[REQ_FPU] = 5'd3; r_data[REQ_FPU] = 32'h3F80_0000;
    grant_cycle(3'b010, "ret_f3_grant");
    step();
    REQ_VALID = 3'b100; r_addr[REQ_LSU] = 5'd0; r_data[REQ_LSU] = 32'h1234_5678;
    REQ_FLOAT = 3'b010;
    grant_cycle(3'b100, "ret_x0_grant");

    // Same-cycle issue and retire of x7: the set wins.
    step();
    REQ_VALID = 3'b001; r_addr[REQ_ALU] = 5'd7; r_data[REQ_ALU] = 32'h0000_0077;
    ISSUE_VALID = 1'b1; ISSUE_ADDR = 5'd7; ISSUE_FLOAT = 1'b0;
    CHK_RDADDR = 5'd7;
    grant_cycle(3'b001, "ret_x7_grant");
    chk("issue_x7_rd_free", HAZARD, 1'b0);
    step();
    REQ_VALID = '0; ISSUE_VALID = 1'b0; CHK_RDADDR = 5'd0; CHK_RS2ADDR = 5'd7;
    #3 chk("waw_x7_set_wins", HAZARD, 1'b1);

    // Mid-operation reset with x9 busy and the FPU pending; ptr is 1 here.
    step();
    CHK_RS2ADDR = 5'd0;
    ISSUE_VALID = 1'b1; ISSUE_ADDR = 5'd9; CHK_RDADDR = 5'd9;
    #3 chk("issue_x9_rd_free", HAZARD, 1'b0);
    step();
    RST = 1'b1;
    ISSUE_ADDR = 5'd12; CHK_RDADDR = 5'd0; CHK_RS1ADDR = 5'd9;
    REQ_VALID = 3'b010; r_addr[REQ_FPU] = 5'd4; r_data[REQ_FPU] = 32'h0000_0044;
    #3;
    chk("rst_mid_ready", REQ_READY, 32'd0);
    chk("rst_mid_x9_busy", HAZARD, 1'b1);
    step();
    RST = 1'b0;
    ISSUE_VALID = 1'b0;
    CHK_RS2ADDR = 5'd7; CHK_RDADDR = 5'd12;
    REQ_VALID = 3'b111;
    r_addr[REQ_ALU] = 5'd10; r_data[REQ_ALU] = 32'h0000_0A10;
    r_addr[REQ_LSU] = 5'd11; r_data[REQ_LSU] = 32'h0000_0B11;
    grant_cycle(3'b001, "rst_ptr0_grant");
    chk("rst_busy_cleared", HAZARD, 1'b0);
    chk("rst_mid_we", WE, 1'b0);
    step();
    REQ_VALID = '0;
    CHK_RS1ADDR = 5'd0; CHK_RS2ADDR = 5'd0; CHK_RDADDR = 5'd0;
    step();
    step();
    mon_en = 1'b0;
    chk("queue_drained", expq.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
